// File: rtl/spie_slave_if.sv
// SPI-slave pin and host-side signal bundle.
// The slave modport is the block's view; the master modport is the driver's view.
// Interface only: no logic, no latency, no flow control.
interface spie_slave_if;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        msbyte_first;
  logic [1:0]  data_width;
  logic [31:0] data_tx;
  logic        tx_wr;
  logic        tx_rdy;
  logic [31:0] data_rx;
  logic        rx_valid;
  logic        busy;
  logic        overrun;
  logic        underrun;
  logic        clr_err;

  modport slave (
    input  cs_n, sclk, mosi, msbyte_first, data_width, data_tx, tx_wr, clr_err,
    output miso, tx_rdy, data_rx, rx_valid, busy, overrun, underrun
  );

  modport master (
    output cs_n, sclk, mosi, msbyte_first, data_width, data_tx, tx_wr, clr_err,
    input  miso, tx_rdy, data_rx, rx_valid, busy, overrun, underrun
  );
endinterface

// File: rtl/spie_slave.sv
// SPI slave (sclk idles high, data sampled on rise, shifted on fall), 8/16/32-bit words.
// Latency: rx word appears ~3 clk after the completing sclk rise (2-flop sync + register).
// No backpressure: tx holding register is overwritten by tx_wr; missed reads flag overrun.
module spie_slave (
  input  logic        clk,
  input  logic        rst,
  spie_slave_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [1:0]  cs_sync, sclk_sync, mosi_sync;
  logic        cs_d, sclk_d;
  logic        cs_fall, sclk_rise, sclk_fall;
  logic        msb_l;
  logic [1:0]  width_l;
  logic [4:0]  bitcnt, last_bit;
  logic [31:0] tx_sh, rx_sh, rx_next, rx_word;
  logic [31:0] hold, tx_load;
  logic        hold_full, seen_rise, reload_pend, unack;
  logic        ld_msb, done, load_now;
  logic [1:0]  ld_width;
  logic        miso_r, rx_valid_r, overrun_r, underrun_r;
  logic [31:0] data_rx_r;

  // Arrange a word so bit 31 is the first bit on the wire; unused tail bits are 1.
  function automatic logic [31:0] wire_order(input logic [31:0] w, input logic [1:0] wd,
                                             input logic msb);
    logic [31:0] r;
    case (wd)
      2'b10:   r = msb ? {w[15:0], 16'hFFFF} : {w[7:0], w[15:8], 16'hFFFF};
      2'b01:   r = msb ? w : {w[7:0], w[15:8], w[23:16], w[31:24]};
      default: r = {w[7:0], 24'hFF_FFFF};
    endcase
    return r;
  endfunction

  // Input synchronizers, intentionally not reset: a cs_n held low across reset
  // must not look like a new falling edge once reset is released.
  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[0], bus.cs_n};
    sclk_sync <= {sclk_sync[0], bus.sclk};
    mosi_sync <= {mosi_sync[0], bus.mosi};
    cs_d      <= cs_sync[1];
    sclk_d    <= sclk_sync[1];
  end

  assign cs_fall   = cs_d & ~cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;

  // Word geometry, tx reload value and rx word assembly.
  always_comb begin
    case (width_l)
      2'b10:   last_bit = 5'd15;
      2'b01:   last_bit = 5'd31;
      default: last_bit = 5'd7;
    endcase
    ld_msb   = (state == IDLE) ? bus.msbyte_first : msb_l;
    ld_width = (state == IDLE) ? bus.data_width : width_l;
    tx_load  = hold_full ? wire_order(hold, ld_width, ld_msb) : 32'hFFFF_FFFF;
    rx_next  = {rx_sh[30:0], mosi_sync[1]};
    case (width_l)
      2'b10:   rx_word = msb_l ? {16'h0, rx_next[15:0]} : {16'h0, rx_next[7:0], rx_next[15:8]};
      2'b01:   rx_word = msb_l ? rx_next :
                         {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
      default: rx_word = {24'h0, rx_next[7:0]};
    endcase
    done     = (state == ACTIVE) && !cs_sync[1] && sclk_rise && (bitcnt == last_bit);
    load_now = ((state == IDLE) && cs_fall) ||
               ((state == ACTIVE) && !cs_sync[1] && sclk_fall && reload_pend);
  end

  // Selection FSM, shifters, holding register and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      msb_l       <= 1'b1;
      width_l     <= 2'b00;
      bitcnt      <= 5'd0;
      tx_sh       <= 32'hFFFF_FFFF;
      rx_sh       <= 32'hFFFF_FFFF;
      hold        <= 32'h0;
      hold_full   <= 1'b0;
      seen_rise   <= 1'b0;
      reload_pend <= 1'b0;
      unack       <= 1'b0;
      miso_r      <= 1'b1;
      rx_valid_r  <= 1'b0;
      data_rx_r   <= 32'h0;
      overrun_r   <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      // A load on the same cycle as tx_wr takes the old contents; the new data stays held.
      if (bus.tx_wr) begin
        hold      <= bus.data_tx;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end
      // Error events take priority over clr_err.
      underrun_r <= (load_now && !hold_full) || (underrun_r && !bus.clr_err);
      overrun_r  <= (done && unack) || (overrun_r && !bus.clr_err);
      unack      <= done || (unack && !(bus.tx_wr || bus.clr_err));

      case (state)
        IDLE: begin
          miso_r <= 1'b1;
          if (cs_fall) begin
            state       <= ACTIVE;
            msb_l       <= bus.msbyte_first;
            width_l     <= bus.data_width;
            bitcnt      <= 5'd0;
            tx_sh       <= tx_load;
            miso_r      <= tx_load[31];
            seen_rise   <= 1'b0;
            reload_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_sync[1]) begin
            state       <= IDLE;
            bitcnt      <= 5'd0;
            miso_r      <= 1'b1;
            seen_rise   <= 1'b0;
            reload_pend <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh     <= rx_next;
            seen_rise <= 1'b1;
            if (done) begin
              data_rx_r   <= rx_word;
              rx_valid_r  <= 1'b1;
              bitcnt      <= 5'd0;
              seen_rise   <= 1'b0;
              reload_pend <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 5'd1;
            end
          end else if (sclk_fall) begin
            if (reload_pend) begin
              tx_sh       <= tx_load;
              miso_r      <= tx_load[31];
              reload_pend <= 1'b0;
            end else if (seen_rise) begin
              tx_sh  <= {tx_sh[30:0], 1'b1};
              miso_r <= tx_sh[30];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso     = miso_r;
  assign bus.tx_rdy   = ~hold_full;
  assign bus.data_rx  = data_rx_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.busy     = (state == ACTIVE);
  assign bus.overrun  = overrun_r;
  assign bus.underrun = underrun_r;
endmodule

// File: tb/tb_spie_slave.sv
// Directed bench for spie_slave: a master model drives sclk/mosi and captures miso,
// a transaction-level model predicts words, flags and miso streams.
// A per-cycle monitor matches every rx_valid against the expected word queue.
module tb_spie_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  spie_slave_if bus_i();

  spie_slave dut (.clk(clk), .rst(rst), .bus(bus_i));

  always #5 clk = ~clk;

  localparam int H = 6;  // clk cycles per sclk half period

  int n_chk  = 0;
  int n_fail = 0;
  int n_rxv  = 0;

  // Transaction-level model state
  logic [31:0] m_hold, m_tx;
  bit          m_full, m_under, m_over, m_unack, m_reload;
  logic [31:0] exp_q[$];
  int          width_bits;
  bit          msb_mode;
  logic        prev_vld;
  logic [31:0] cap;
  int          rx_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit order on the wire, left-aligned (bit 31 goes first), unused tail = 1.
  function automatic logic [31:0] stream(input logic [31:0] w, input int nb, input bit msb);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    if (msb) begin
      for (int i = 0; i < nb; i++) s[31-i] = w[nb-1-i];
    end else begin
      for (int k = 0; k < nb / 8; k++)
        for (int j = 0; j < 8; j++) s[31-8*k-j] = w[8*k+7-j];
    end
    return s;
  endfunction

  function automatic logic [31:0] mask(input int nb);
    return (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
  endfunction

  function automatic logic [1:0] wcode(input int nb);
    return (nb == 16) ? 2'b10 : (nb == 32) ? 2'b01 : 2'b00;
  endfunction

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    bus_i.data_tx = d;
    bus_i.tx_wr   = 1'b1;
    @(negedge clk);
    bus_i.tx_wr = 1'b0;
    m_hold = d; m_full = 1; m_unack = 0;
  endtask

  task automatic clr();
    @(negedge clk);
    bus_i.clr_err = 1'b1;
    @(negedge clk);
    bus_i.clr_err = 1'b0;
    m_under = 0; m_over = 0; m_unack = 0;
  endtask

  task automatic model_load();
    if (m_full) begin m_tx = m_hold; m_full = 0; end
    else begin m_tx = 32'hFFFF_FFFF; m_under = 1; end
  endtask

  task automatic sel(input int nb, input bit msb);
    width_bits = nb; msb_mode = msb;
    bus_i.data_width   = wcode(nb);
    bus_i.msbyte_first = msb;
    bus_i.cs_n         = 1'b0;
    model_load();
    m_reload = 0;
    repeat (H) @(negedge clk);
  endtask

  task automatic desel();
    bus_i.cs_n = 1'b1;
    m_reload   = 0;
    repeat (H) @(negedge clk);
  endtask

  // Clock nbits of word w out on mosi; return what miso carried (left-aligned).
  task automatic xfer(input logic [31:0] w, input int nbits, output logic [31:0] c);
    logic [31:0] s;
    s = stream(w, width_bits, msb_mode);
    c = 32'hFFFF_FFFF;
    if (m_reload) begin model_load(); m_reload = 0; end
    for (int i = 0; i < nbits; i++) begin
      bus_i.sclk = 1'b0;
      bus_i.mosi = s[31-i];
      repeat (H) @(negedge clk);
      c[31-i] = bus_i.miso;
      if (i == width_bits - 1) begin
        exp_q.push_back(w & mask(width_bits));
        if (m_unack) m_over = 1;
        m_unack  = 1;
        m_reload = 1;
      end
      bus_i.sclk = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] c);
    chk(name, c, stream(m_tx, width_bits, msb_mode));
  endtask

  task automatic flags(input string name, input logic exp_busy);
    chk({name, " busy"}, bus_i.busy, exp_busy);
    chk({name, " tx_rdy"}, bus_i.tx_rdy, !m_full);
    chk({name, " underrun"}, bus_i.underrun, m_under);
    chk({name, " overrun"}, bus_i.overrun, m_over);
    chk({name, " words outstanding"}, exp_q.size(), 0);
  endtask

  // Per-cycle monitor: every rx_valid must match the next expected word.
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
    end else begin
      if (bus_i.rx_valid) begin
        n_rxv++;
        chk("rx_valid with word pending", exp_q.size(), 1);
        if (exp_q.size() != 0) chk("data_rx", bus_i.data_rx, exp_q.pop_front());
        chk("rx_valid pulse width", prev_vld, 1'b0);
      end
      if (!bus_i.busy) chk("miso idle high", bus_i.miso, 1'b1);
      prev_vld <= bus_i.rx_valid;
    end
  end

  initial begin
    bus_i.cs_n = 1'b1; bus_i.sclk = 1'b1; bus_i.mosi = 1'b1;
    bus_i.msbyte_first = 1'b1; bus_i.data_width = 2'b00;
    bus_i.data_tx = 32'h0; bus_i.tx_wr = 1'b0; bus_i.clr_err = 1'b0;
    m_hold = 0; m_tx = '1; m_full = 0; m_under = 0; m_over = 0; m_unack = 0; m_reload = 0;
    width_bits = 8; msb_mode = 1;
    repeat (5) @(negedge clk);
    chk("reset miso", bus_i.miso, 1'b1);
    chk("reset tx_rdy", bus_i.tx_rdy, 1'b1);
    chk("reset data_rx", bus_i.data_rx, 32'h0);
    chk("reset rx_valid", bus_i.rx_valid, 1'b0);
    chk("reset busy", bus_i.busy, 1'b0);
    chk("reset overrun", bus_i.overrun, 1'b0);
    chk("reset underrun", bus_i.underrun, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8-bit MSByte first: tx A5, rx 3C
    wr(32'hA5);
    chk("t1 tx_rdy after write", bus_i.tx_rdy, 1'b0);
    sel(8, 1);
    flags("t1 selected", 1'b1);
    xfer(32'h3C, 8, cap);
    chk("t1 miso bits", cap[31:24], 8'hA5);
    chk_word("t1 miso model", cap);
    desel();
    chk("t1 data_rx", bus_i.data_rx, 32'h0000_003C);
    chk("t1 rx_valid count", n_rxv, 1);
    flags("t1 end", 1'b0);

    // 32-bit LSByte first
    wr(32'h1122_3344);
    sel(32, 0);
    xfer(32'hDEAD_BEEF, 32, cap);
    chk("t2 miso bytes 44,33,22,11", cap, 32'h4433_2211);
    chk_word("t2 miso model", cap);
    desel();
    chk("t2 data_rx", bus_i.data_rx, 32'hDEAD_BEEF);
    flags("t2 end", 1'b0);

    // 16-bit back-to-back words with a write between them
    wr(32'hCAFE);
    sel(16, 1);
    rx_before = n_rxv;
    xfer(32'h1234, 16, cap);
    chk_word("t3 word1 miso", cap);
    wr(32'hBEEF);
    xfer(32'h5678, 16, cap);
    chk("t3 word2 miso", cap[31:16], 16'hBEEF);
    chk_word("t3 word2 miso model", cap);
    desel();
    chk("t3 rx_valid count", n_rxv - rx_before, 2);
    chk("t3 data_rx", bus_i.data_rx, 32'h0000_5678);
    flags("t3 end", 1'b0);

    // 16-bit LSByte first
    wr(32'h0F1E);
    sel(16, 0);
    xfer(32'hA1B2, 16, cap);
    chk("t4 miso bytes", cap[31:16], 16'h1E0F);
    desel();
    chk("t4 data_rx", bus_i.data_rx, 32'h0000_A1B2);
    flags("t4 end", 1'b0);

    // Underrun: select with nothing written
    clr();
    sel(8, 1);
    xfer(32'h5A, 8, cap);
    chk("t5 miso all ones", cap[31:24], 8'hFF);
    desel();
    chk("t5 underrun set", bus_i.underrun, 1'b1);
    flags("t5 end", 1'b0);
    clr();
    chk("t5 underrun cleared", bus_i.underrun, 1'b0);
    flags("t5 cleared", 1'b0);

    // Abort after 5 bits, then a full transfer
    wr(32'h5A);
    sel(8, 1);
    rx_before = n_rxv;
    xfer(32'hC3, 5, cap);
    desel();
    chk("t6 no rx_valid on abort", n_rxv - rx_before, 0);
    flags("t6 aborted", 1'b0);
    wr(32'h96);
    sel(8, 1);
    xfer(32'h69, 8, cap);
    chk("t6 miso after abort", cap[31:24], 8'h96);
    desel();
    chk("t6 data_rx", bus_i.data_rx, 32'h0000_0069);
    flags("t6 end", 1'b0);

    // Overrun: two completions with no write or clear in between
    clr();
    sel(8, 1);
    xfer(32'h11, 8, cap);
    xfer(32'h22, 8, cap);
    desel();
    chk("t7 overrun set", bus_i.overrun, 1'b1);
    flags("t7 end", 1'b0);
    clr();
    chk("t7 overrun cleared", bus_i.overrun, 1'b0);

    // Reset mid-word
    wr(32'h77);
    sel(8, 1);
    rx_before = n_rxv;
    xfer(32'hAA, 3, cap);
    bus_i.sclk = 1'b0;
    repeat (H) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t8 rst busy", bus_i.busy, 1'b0);
    chk("t8 rst miso", bus_i.miso, 1'b1);
    chk("t8 rst tx_rdy", bus_i.tx_rdy, 1'b1);
    chk("t8 rst data_rx", bus_i.data_rx, 32'h0);
    chk("t8 rst rx_valid", bus_i.rx_valid, 1'b0);
    chk("t8 rst overrun", bus_i.overrun, 1'b0);
    chk("t8 rst underrun", bus_i.underrun, 1'b0);
    rst = 1'b0;
    m_full = 0; m_under = 0; m_over = 0; m_unack = 0; m_reload = 0;
    bus_i.sclk = 1'b1;
    repeat (4 * H) @(negedge clk);
    chk("t8 waits for fresh select", bus_i.busy, 1'b0);
    chk("t8 no rx_valid", n_rxv - rx_before, 0);
    desel();
    wr(32'hC5);
    sel(8, 0);
    xfer(32'h3A, 8, cap);
    chk("t8 miso after reset", cap[31:24], 8'hC5);
    desel();
    chk("t8 data_rx after reset", bus_i.data_rx, 32'h0000_003A);
    flags("t8 end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
